// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, RV32I encodings and one-hot ALU op indices for the issue stage
package alu_pkg;
    localparam int XLEN = 32;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_XOR = 2;
    localparam int ALU_OR  = 3;
    localparam int ALU_AND = 4;
    typedef logic [4:0] alu_op_t;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps an RV32I word onto a one-hot ALU op, its I-immediate and legality
module alu_op_decoder import alu_pkg::*; #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [31:0]     instr,
    output alu_op_t         op,
    output logic [XLEN-1:0] imm,
    output logic            use_imm,
    output logic            illegal,
    output logic            wb_en
);
    logic is_op, is_imm, base_op, arith;
    logic [2:0] f3;
    assign f3      = instr[14:12];
    assign is_op   = instr[6:0] == OPC_OP;
    assign is_imm  = instr[6:0] == OPC_OP_IMM;
    assign base_op = is_op && instr[31:25] == F7_BASE;
    assign arith   = base_op || is_imm;
    // funct3/funct7 terms are mutually exclusive, so at most one bit can ever be set
    assign op[ALU_ADD] = arith && f3 == F3_ADD;
    assign op[ALU_SUB] = is_op && instr[31:25] == F7_ALT && f3 == F3_ADD;
    assign op[ALU_XOR] = arith && f3 == F3_XOR;
    assign op[ALU_OR]  = arith && f3 == F3_OR;
    assign op[ALU_AND] = arith && f3 == F3_AND;
    assign imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign use_imm = is_imm;
    assign illegal = ~|op;
    assign wb_en   = !illegal && instr[11:7] != 5'd0;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered decode-to-execute stage with valid/ready handshake (optional forwarding: ALU_ISSUE_FWD_EN)
module alu_issue_stage import alu_pkg::*; #(
    parameter int XLEN       = alu_pkg::XLEN,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_rs1_val,
    input  logic [XLEN-1:0]       in_rs2_val,
    input  logic                  flush,
`ifdef ALU_ISSUE_FWD_EN
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]       fwd_data,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output alu_op_t               out_op,
    output logic [XLEN-1:0]       out_arg1,
    output logic [XLEN-1:0]       out_arg2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wb_en,
    output logic                  out_illegal
);
    alu_op_t         dec_op;
    logic [XLEN-1:0] dec_imm, src1, src2;
    logic            dec_use_imm, dec_illegal, dec_wb_en, accept;
    alu_op_decoder #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .op      (dec_op),
        .imm     (dec_imm),
        .use_imm (dec_use_imm),
        .illegal (dec_illegal),
        .wb_en   (dec_wb_en)
    );
`ifdef ALU_ISSUE_FWD_EN
    logic fwd_hit1, fwd_hit2;
    assign fwd_hit1 = fwd_valid && fwd_rd != '0 && fwd_rd == in_instr[19:15];
    assign fwd_hit2 = fwd_valid && fwd_rd != '0 && fwd_rd == in_instr[24:20];
    assign src1 = fwd_hit1 ? fwd_data : in_rs1_val;
    assign src2 = fwd_hit2 ? fwd_data : in_rs2_val;
`else
    assign src1 = in_rs1_val;
    assign src2 = in_rs2_val;
`endif
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    // Flush wins; otherwise refill on accept (also when draining) or empty once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_arg1    <= '0;
            out_arg2    <= '0;
            out_rd      <= '0;
            out_wb_en   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_op      <= dec_op;
            out_arg1    <= dec_illegal ? '0 : src1;
            out_arg2    <= dec_illegal ? '0 : dec_use_imm ? dec_imm : src2;
            out_rd      <= in_instr[11:7];
            out_wb_en   <= dec_wb_en;
            out_illegal <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for alu_issue_stage
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_wb_en, out_illegal;
    logic [31:0] in_instr, in_rs1_val, in_rs2_val, out_arg1, out_arg2;
    logic [4:0]  out_op, out_rd;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd = '0;
    logic [31:0] fwd_data = '0;
`endif
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .flush       (flush),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_arg1    (out_arg1),
        .out_arg2    (out_arg2),
        .out_rd      (out_rd),
        .out_wb_en   (out_wb_en),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic apply(input string tag, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] eop, input logic [31:0] ea1, input logic [31:0] ea2,
                         input logic [4:0] erd, input logic ewb, input logic eill);
        in_valid = 1'b1; in_instr = ins; in_rs1_val = r1; in_rs2_val = r2; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".op"}, {27'd0, out_op}, {27'd0, eop});
        chk({tag, ".arg1"}, out_arg1, ea1);
        chk({tag, ".arg2"}, out_arg2, ea2);
        chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, erd});
        chk({tag, ".wb"}, {31'd0, out_wb_en}, {31'd0, ewb});
        chk({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, eill});
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd9);
        in_rs1_val = 32'h11; in_rs2_val = 32'h22;
        tick(); tick();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.op", {27'd0, out_op}, 32'd0);
        chk("rst.arg1", out_arg1, 32'd0);
        chk("rst.arg2", out_arg2, 32'd0);
        chk("rst.rd", {27'd0, out_rd}, 32'd0);
        chk("rst.wb", {31'd0, out_wb_en}, 32'd0);
        chk("rst.ill", {31'd0, out_illegal}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("rel.valid", {31'd0, out_valid}, 32'd0);
        apply("sub",  r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd5), 32'd10, 32'd3, 5'b00010, 32'd10, 32'd3, 5'd5, 1'b1, 1'b0);
        apply("andi", i_type(12'hFFF, 5'd1, 3'b111, 5'd0), 32'h1234, 32'd99, 5'b10000, 32'h1234, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        apply("add",  r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), 32'd7, 32'd8, 5'b00001, 32'd7, 32'd8, 5'd9, 1'b1, 1'b0);
        apply("xor",  r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd10), 32'hF0, 32'hFF, 5'b00100, 32'hF0, 32'hFF, 5'd10, 1'b1, 1'b0);
        apply("or",   r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd11), 32'h5, 32'hA, 5'b01000, 32'h5, 32'hA, 5'd11, 1'b1, 1'b0);
        apply("and",  r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd12), 32'hC, 32'hA, 5'b10000, 32'hC, 32'hA, 5'd12, 1'b1, 1'b0);
        apply("addi", i_type(12'h800, 5'd1, 3'b000, 5'd4), 32'd5, 32'd6, 5'b00001, 32'd5, 32'hFFFF_F800, 5'd4, 1'b1, 1'b0);
        apply("xori", i_type(12'h7FF, 5'd1, 3'b100, 5'd13), 32'h77, 32'd1, 5'b00100, 32'h77, 32'h7FF, 5'd13, 1'b1, 1'b0);
        apply("subxor", r_type(7'h20, 5'd2, 5'd1, 3'b100, 5'd6), 32'd1, 32'd2, 5'b00000, 32'd0, 32'd0, 5'd6, 1'b0, 1'b1);
        apply("sll",  r_type(7'h00, 5'd2, 5'd1, 3'b001, 5'd7), 32'd1, 32'd2, 5'b00000, 32'd0, 32'd0, 5'd7, 1'b0, 1'b1);
        apply("slli", i_type(12'h003, 5'd1, 3'b001, 5'd8), 32'd1, 32'd2, 5'b00000, 32'd0, 32'd0, 5'd8, 1'b0, 1'b1);
        apply("ori",  i_type(12'h123, 5'd1, 3'b110, 5'd14), 32'h40, 32'd2, 5'b01000, 32'h40, 32'h123, 5'd14, 1'b1, 1'b0);
        // backpressure: the ori beat must stay frozen while new beats wait
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd15); in_rs1_val = 32'hF0F0; in_rs2_val = 32'h0FF0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("stall.valid", {31'd0, out_valid}, 32'd1);
            chk("stall.op", {27'd0, out_op}, 32'b01000);
            chk("stall.arg2", out_arg2, 32'h123);
            chk("stall.rd", {27'd0, out_rd}, 32'd14);
        end
        out_ready = 1'b1;
        #1 chk("refill.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("refill.valid", {31'd0, out_valid}, 32'd1);
        chk("refill.op", {27'd0, out_op}, 32'b10000);
        chk("refill.arg1", out_arg1, 32'hF0F0);
        chk("refill.arg2", out_arg2, 32'h0FF0);
        chk("refill.rd", {27'd0, out_rd}, 32'd15);
        apply("lui", {20'h12345, 5'd3, 7'b0110111}, 32'h9, 32'h9, 5'b00000, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
        // flush while full with an incoming beat: both are discarded
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1;
        in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd9);
        tick();
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush.after", {31'd0, out_valid}, 32'd0);
        // a held beat drains after one ready cycle
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("drain.load", {31'd0, out_valid}, 32'd1);
        tick();
        chk("drain.empty", {31'd0, out_valid}, 32'd0);
`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b1; fwd_rd = 5'd7; fwd_data = 32'hDEAD;
        apply("fwd.add", r_type(7'h00, 5'd7, 5'd7, 3'b000, 5'd3), 32'd1, 32'd2, 5'b00001, 32'hDEAD, 32'hDEAD, 5'd3, 1'b1, 1'b0);
        apply("fwd.addi", i_type(12'h007, 5'd7, 3'b000, 5'd3), 32'd1, 32'd2, 5'b00001, 32'hDEAD, 32'h7, 5'd3, 1'b1, 1'b0);
        fwd_rd = 5'd0;
        apply("fwd.x0", r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd3), 32'd1, 32'd2, 5'b00001, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);
        fwd_valid = 1'b0;
`endif
        // asynchronous reset mid-stream drops the held beat immediately
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("mid.load", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("mid.valid", {31'd0, out_valid}, 32'd0);
        chk("mid.op", {27'd0, out_op}, 32'd0);
        rst_n = 1'b1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
